// File: rtl/ps2_host_port.sv
// PS/2 host link layer: filtered receive of device frames and
// inhibit / request-to-send transmit of host command bytes.
module ps2_host_port #(
  parameter int CLKFREQ     = 28000000,
  parameter int INHIBIT_CYC = CLKFREQ / 10000,
  parameter int TIMEOUT_CYC = CLKFREQ / 500,
  parameter int FILTER_LEN  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2clk_i,
  input  logic       ps2dat_i,
  output logic       ps2clk_oe,
  output logic       ps2dat_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_err,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] RX         = 3'd1;
  localparam logic [2:0] TX_INHIBIT = 3'd2;
  localparam logic [2:0] TX_REQ     = 3'd3;
  localparam logic [2:0] TX_BITS    = 3'd4;
  localparam logic [2:0] TX_ACK     = 3'd5;

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [FW-1:0] FMAX    = FW'(FILTER_LEN - 1);
  localparam logic [16:0]   INH_END = 17'(INHIBIT_CYC - 1);
  localparam logic [16:0]   TO_LIM  = 17'(TIMEOUT_CYC);

  logic [1:0]    csync_q, dsync_q;
  logic          clk_s, dat_s;
  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          fall;

  logic [2:0]  state_q, state_d;
  logic [16:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]  bit_q, bit_d;
  logic [8:0]  rsh_q, rsh_d;
  logic [9:0]  tsh_q, tsh_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        rx_err_q, rx_err_d;
  logic        tx_done_q, tx_done_d;
  logic        tx_err_q, tx_err_d;
  logic        busy_q, busy_d;
  logic        clk_oe_q, clk_oe_d;
  logic        dat_oe_q, dat_oe_d;
  logic        ack_seen_q, ack_seen_d;
  logic        ack_ok_q, ack_ok_d;
  logic        timeout, tx_abort;

  assign clk_s = csync_q[1];
  assign dat_s = dsync_q[1];

  // A new clock level is taken only after FILTER_LEN differing samples.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = fcnt_q;
    if (clk_s == filt_q) begin
      fcnt_d = '0;
    end else if (fcnt_q == FMAX) begin
      filt_d = clk_s;
      fcnt_d = '0;
    end else begin
      fcnt_d = fcnt_q + 1'b1;
    end
  end

  assign fall = filt_q & ~filt_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    rsh_d      = rsh_q;
    tsh_d      = tsh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_err_d   = 1'b0;
    tx_done_d  = 1'b0;
    tx_err_d   = 1'b0;
    busy_d     = busy_q;
    clk_oe_d   = clk_oe_q;
    dat_oe_d   = dat_oe_q;
    ack_seen_d = ack_seen_q;
    ack_ok_d   = ack_ok_q;
    tx_abort   = 1'b0;
    cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + 17'd1;
    timeout    = (cnt_q >= TO_LIM);

    if (tx_start && !busy_q) begin
      busy_d = 1'b1;
      tsh_d  = {1'b1, ~^tx_data, tx_data};
    end

    unique case (state_q)
      IDLE: begin
        if (fall && !dat_s) begin
          state_d = RX;
          bit_d   = 4'd0;
          cnt_d   = '0;
        end else if (busy_q) begin
          state_d  = TX_INHIBIT;
          cnt_d    = '0;
          clk_oe_d = 1'b1;
          dat_oe_d = 1'b0;
        end
      end
      RX: begin
        if (fall) begin
          cnt_d = '0;
          if (bit_q == 4'd9) begin
            state_d = IDLE;
            if (^rsh_q && dat_s) begin
              rx_data_d  = rsh_q[7:0];
              rx_valid_d = 1'b1;
            end else begin
              rx_err_d = 1'b1;
            end
          end else begin
            rsh_d = {dat_s, rsh_q[8:1]};
            bit_d = bit_q + 4'd1;
          end
        end else if (timeout) begin
          rx_err_d = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      TX_INHIBIT: begin
        if (cnt_q >= INH_END) begin
          state_d  = TX_REQ;
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b1;
          cnt_d    = '0;
          bit_d    = 4'd0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      TX_REQ, TX_BITS: begin
        if (fall) begin
          dat_oe_d = ~tsh_q[0];
          tsh_d    = {1'b1, tsh_q[9:1]};
          bit_d    = bit_q + 4'd1;
          cnt_d    = '0;
          state_d  = (bit_q == 4'd9) ? TX_ACK : TX_BITS;
          ack_seen_d = 1'b0;
        end else if (timeout) begin
          tx_abort = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      TX_ACK: begin
        if (!ack_seen_q && fall) begin
          ack_seen_d = 1'b1;
          ack_ok_d   = ~dat_s;
          cnt_d      = '0;
        end else if (ack_seen_q && filt_q && dat_s) begin
          state_d   = IDLE;
          tx_done_d = ack_ok_q;
          tx_err_d  = ~ack_ok_q;
          busy_d    = 1'b0;
        end else if (timeout) begin
          tx_abort = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase

    if (tx_abort) begin
      state_d  = IDLE;
      clk_oe_d = 1'b0;
      dat_oe_d = 1'b0;
      tx_err_d = 1'b1;
      busy_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csync_q    <= 2'b11;
      dsync_q    <= 2'b11;
      filt_q     <= 1'b1;
      fcnt_q     <= '0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      rsh_q      <= '0;
      tsh_q      <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      tx_done_q  <= 1'b0;
      tx_err_q   <= 1'b0;
      busy_q     <= 1'b0;
      clk_oe_q   <= 1'b0;
      dat_oe_q   <= 1'b0;
      ack_seen_q <= 1'b0;
      ack_ok_q   <= 1'b0;
    end else begin
      csync_q    <= {csync_q[0], ps2clk_i};
      dsync_q    <= {dsync_q[0], ps2dat_i};
      filt_q     <= filt_d;
      fcnt_q     <= fcnt_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      rsh_q      <= rsh_d;
      tsh_q      <= tsh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_err_q   <= rx_err_d;
      tx_done_q  <= tx_done_d;
      tx_err_q   <= tx_err_d;
      busy_q     <= busy_d;
      clk_oe_q   <= clk_oe_d;
      dat_oe_q   <= dat_oe_d;
      ack_seen_q <= ack_seen_d;
      ack_ok_q   <= ack_ok_d;
    end
  end

  assign ps2clk_oe = clk_oe_q;
  assign ps2dat_oe = dat_oe_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign rx_err    = rx_err_q;
  assign tx_busy   = busy_q;
  assign tx_done   = tx_done_q;
  assign tx_err    = tx_err_q;

endmodule

// File: tb/tb_ps2_host_port.sv
// Bench for ps2_host_port: device-side PS/2 models drive frames,
// a scoreboard queue checks every rx/tx pulse the port emits.
module tb_ps2_host_port;

  localparam int CLKF = 2800000;
  localparam int INH  = CLKF / 10000;
  localparam int TO   = CLKF / 500;
  localparam int HP   = 60;

  localparam logic [1:0] RXV = 2'd0;
  localparam logic [1:0] RXE = 2'd1;
  localparam logic [1:0] TXD = 2'd2;
  localparam logic [1:0] TXE = 2'd3;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] data;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       glitch = 1'b0;
  logic       ps2clk_i, ps2dat_i;
  logic       ps2clk_oe, ps2dat_oe;
  logic [7:0] rx_data;
  logic       rx_valid, rx_err;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       tx_busy, tx_done, tx_err;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  int rxv_cyc = 0;
  int last_fall = 0;
  ev_t exp_q[$];

  assign ps2clk_i = dev_clk & ~ps2clk_oe & ~glitch;
  assign ps2dat_i = dev_dat & ~ps2dat_oe;

  ps2_host_port #(.CLKFREQ(CLKF)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2clk_i  (ps2clk_i),
    .ps2dat_i  (ps2dat_i),
    .ps2clk_oe (ps2clk_oe),
    .ps2dat_oe (ps2dat_oe),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_err    (rx_err),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done),
    .tx_err    (tx_err)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  task automatic push(input logic [1:0] k, input logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic ev_chk(input logic [1:0] k, input logic [7:0] d);
    ev_t e;
    n_chk++;
    pulse_cnt++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL event: got kind %0d data %h, expected none", k, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind !== k || (k == RXV && e.data !== d)) begin
        n_fail++;
        $display("FAIL event: got kind %0d data %h, expected kind %0d data %h",
                 k, d, e.kind, e.data);
      end
    end
  endtask

  // Monitor: every output pulse must match the head of the queue.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (rx_valid) begin
        rxv_cyc = cyc;
        ev_chk(RXV, rx_data);
      end
      if (rx_err)  ev_chk(RXE, rx_data);
      if (tx_done) ev_chk(TXD, 8'h00);
      if (tx_err)  ev_chk(TXE, 8'h00);
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] frame(input logic [7:0] d,
                                        input bit bad_par,
                                        input bit bad_stop);
    return {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
  endfunction

  task automatic dev_send(input logic [10:0] fr, input int nb,
                          input bit glt);
    for (int i = 0; i < nb; i++) begin
      dev_dat = fr[i];
      if (glt) begin
        wait_cyc(HP / 2);
        glitch = 1'b1;
        wait_cyc(3);
        glitch = 1'b0;
        wait_cyc(HP - HP / 2 - 3);
      end else begin
        wait_cyc(HP);
      end
      dev_clk = 1'b0;
      last_fall = cyc;
      wait_cyc(HP);
      dev_clk = 1'b1;
    end
    wait_cyc(HP);
    dev_dat = 1'b1;
  endtask

  task automatic dev_recv(input int nf, input bit ack,
                          output logic [9:0] bits, output int t_rise);
    int n;
    bit seen;
    bits = '0;
    t_rise = -1;
    seen = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (ps2clk_oe) begin
        seen = 1'b1;
        break;
      end
    end
    chk("inhibit seen", 32'(seen), 32'd1);
    if (!seen) return;
    t_rise = cyc;
    n = 1;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (!ps2clk_oe) break;
      n++;
    end
    chk("inhibit length", n, INH);
    chk("start bit at release", 32'(ps2dat_oe), 32'd1);
    wait_cyc(20);
    for (int i = 0; i < nf; i++) begin
      if (i == 10) dev_dat = ~ack;
      wait_cyc(HP);
      dev_clk = 1'b0;
      wait_cyc(HP);
      if (i < 10) bits[i] = ps2dat_i;
      dev_clk = 1'b1;
    end
    wait_cyc(HP / 2);
    dev_dat = 1'b1;
  endtask

  task automatic tx_req(input logic [7:0] d, input bit exp_ev,
                        input logic [1:0] k);
    if (exp_ev) push(k, 8'h00);
    tx_data = d;
    tx_start = 1'b1;
    wait_cyc(1);
    tx_start = 1'b0;
  endtask

  initial begin
    logic [9:0] bits;
    int t;
    int d;
    int n;
    int p;

    wait_cyc(3);
    chk("reset clk_oe", 32'(ps2clk_oe), 32'd0);
    chk("reset dat_oe", 32'(ps2dat_oe), 32'd0);
    chk("reset rx_data", 32'(rx_data), 32'h00);
    chk("reset rx_valid", 32'(rx_valid), 32'd0);
    chk("reset rx_err", 32'(rx_err), 32'd0);
    chk("reset tx_busy", 32'(tx_busy), 32'd0);
    chk("reset tx_done", 32'(tx_done), 32'd0);
    chk("reset tx_err", 32'(tx_err), 32'd0);
    rst_n = 1'b1;
    wait_cyc(20);

    push(RXV, 8'h1C);
    dev_send(frame(8'h1C, 0, 0), 11, 0);
    wait_cyc(30);
    chk("rx_data 1C", 32'(rx_data), 32'h1C);

    push(RXE, 8'h00);
    dev_send(frame(8'h1C, 1, 0), 11, 0);
    wait_cyc(30);
    push(RXE, 8'h00);
    dev_send(frame(8'hA5, 0, 1), 11, 0);
    wait_cyc(30);
    chk("rx_data kept on error", 32'(rx_data), 32'h1C);

    push(RXE, 8'h00);
    dev_send(frame(8'hF0, 0, 0), 5, 0);
    d = -1;
    for (int i = 0; i < TO + 200; i++) begin
      @(negedge clk);
      if (rx_err) begin
        d = cyc - last_fall;
        break;
      end
    end
    chk("timeout rx_err seen", 32'(d >= 0), 32'd1);
    chk("timeout latency", 32'(d >= TO && d <= TO + 16), 32'd1);
    wait_cyc(20);
    push(RXV, 8'hF0);
    dev_send(frame(8'hF0, 0, 0), 11, 0);
    wait_cyc(30);
    chk("rx_data F0 after timeout", 32'(rx_data), 32'hF0);

    tx_req(8'hED, 1, TXD);
    chk("busy after start", 32'(tx_busy), 32'd1);
    dev_recv(11, 1, bits, t);
    chk("tx bits ED", 32'(bits), 32'h3ED);
    wait_cyc(40);
    chk("busy cleared ED", 32'(tx_busy), 32'd0);

    push(RXV, 8'h5A);
    fork
      dev_send(frame(8'h5A, 0, 0), 11, 0);
      begin
        wait_cyc(9 * HP);
        tx_req(8'h12, 1, TXD);
        wait_cyc(5);
        tx_req(8'h34, 0, TXD);
      end
      dev_recv(11, 1, bits, t);
    join
    chk("inhibit after rx_valid", t - rxv_cyc, 1);
    chk("tx bits 12", 32'(bits), 32'h312);
    n = 0;
    repeat (INH + 300) begin
      @(negedge clk);
      if (ps2clk_oe) n++;
    end
    chk("no second frame", n, 0);
    chk("busy cleared 12", 32'(tx_busy), 32'd0);

    push(RXV, 8'h3C);
    wait_cyc(1);
    dev_send(frame(8'h3C, 0, 0), 11, 1);
    wait_cyc(30);
    chk("rx_data 3C with glitches", 32'(rx_data), 32'h3C);

    tx_req(8'hF4, 1, TXE);
    dev_recv(11, 0, bits, t);
    chk("tx bits F4", 32'(bits), 32'h2F4);
    wait_cyc(40);
    chk("busy cleared F4", 32'(tx_busy), 32'd0);

    tx_req(8'h77, 0, TXD);
    dev_recv(4, 1, bits, t);
    chk("tx bits 77 partial", 32'(bits[3:0]), 32'h7);
    chk("dat_oe mid TX_BITS", 32'(ps2dat_oe), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset clk_oe", 32'(ps2clk_oe), 32'd0);
    chk("async reset dat_oe", 32'(ps2dat_oe), 32'd0);
    chk("async reset tx_busy", 32'(tx_busy), 32'd0);
    wait_cyc(5);
    rst_n = 1'b1;
    p = pulse_cnt;
    wait_cyc(300);
    chk("no pulses after reset", pulse_cnt - p, 0);
    chk("clk_oe idle after reset", 32'(ps2clk_oe), 32'd0);

    for (int i = 0; i < 2000; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    chk("scoreboard drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
